load_store_unit: RTL and testbench

Initiator side of the data-memory port. Accepts one load or store per handshake from the execute stage, checks alignment and range, and drives the word-aligned memory address, byte enables and lane-replicated write data. For loads, it extracts and sign- or zero-extends the addressed byte, halfword or word from the memory's asynchronous read data. It returns a registered response with valid/ready handshake and error flags.

---
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, alignment/range checks,
// lane steering for stores and extraction/extension of load data.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam longint unsigned BYTE_LIMIT = longint'(MEM_SIZE) * 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic       op_we;
  logic [2:0] op_funct3;
  logic [1:0] op_off;

  logic [1:0]            req_off;
  logic [ADDR_WIDTH-1:0] req_aligned;
  logic                  err_illegal;
  logic                  err_misaligned;
  logic                  err_range;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    return (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0]        shifted;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    shifted = rdata >> {off, 3'b000};
    b8      = shifted[7:0];
    h16     = shifted[15:0];
    case (f3)
      F3_B:    return 32'(b8);
      F3_H:    return 32'(h16);
      F3_BU:   return {24'd0, shifted[7:0]};
      F3_HU:   return {16'd0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  assign req_off     = req_addr[1:0];
  assign req_aligned = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready   = (state == IDLE);

  // Error flags are mutually exclusive: illegal width beats misalignment beats range.
  assign err_illegal    = !funct3_legal(req_we, req_funct3);
  assign err_misaligned = !err_illegal && is_misaligned(req_funct3, req_off);
  assign err_range      = !err_illegal && !err_misaligned && (64'(req_aligned) >= BYTE_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_we           <= 1'b0;
      op_funct3       <= '0;
      op_off          <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_we          <= 1'b0;
      mem_be          <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_we     <= req_we;
            op_funct3 <= req_funct3;
            op_off    <= req_off;
            if (err_illegal || err_misaligned || err_range) begin
              state           <= RESP;
              resp_valid      <= 1'b1;
              resp_rdata      <= '0;
              resp_misaligned <= err_misaligned;
              resp_fault      <= err_illegal || err_range;
            end else begin
              state    <= ACCESS;
              mem_addr <= req_aligned;
              mem_be   <= lane_enables(req_funct3, req_off);
              mem_we   <= req_we;
              if (req_we) mem_wdata <= replicate(req_funct3, req_wdata);
            end
          end
        end
        // Memory read data is sampled at the edge that closes ACCESS.
        ACCESS: begin
          state           <= RESP;
          mem_we          <= 1'b0;
          mem_be          <= 4'b0000;
          resp_valid      <= 1'b1;
          resp_rdata      <= op_we ? '0 : extend_load(op_funct3, op_off, mem_rdata);
          resp_misaligned <= 1'b0;
          resp_fault      <= 1'b0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, stall and reset sequences,
// then random traffic against a byte-array memory model.
module tb_load_store_unit;
  localparam int MS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misaligned, resp_fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [0:MS-1];
  assign mem_rdata = dmem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  logic [7:0] ref_mem [0:4*MS-1];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          lat;
    logic [3:0]  be;
    int          wecyc;
    logic [31:0] mwd;
  } vec_t;

  vec_t dir[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input logic mis,
                              input logic flt, input int lat, input logic [3:0] be,
                              input int wecyc, input logic [31:0] mwd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rdata = rd; v.mis = mis;
    v.fault = flt; v.lat = lat; v.be = be; v.wecyc = wecyc; v.mwd = mwd;
    return v;
  endfunction

  function automatic int access_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Reference behaviour from the access rules, using a flat byte memory.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd);
    vec_t   v;
    int     size, off;
    bit     legal;
    longint val;
    v = mk(we, f3, addr, wd, 32'h0, 1'b0, 1'b0, 1, 4'h0, 0, 32'h0);
    off   = int'(addr % 4);
    size  = access_size(f3);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) v.fault = 1'b1;
    else if (off % size != 0) v.mis = 1'b1;
    else if (addr - 32'(off) >= 32'(4 * MS)) v.fault = 1'b1;
    else begin
      v.lat = 2;
      v.be  = 4'(((1 << size) - 1) << off);
      if (we) begin
        v.wecyc = 1;
        for (int j = 0; j < 4; j++) v.mwd[8*j +: 8] = wd[8*(j % size) +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < size; i++) val = val | (longint'(ref_mem[addr + 32'(i)]) << (8 * i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val - (longint'(1) << (8 * size));
        v.rdata = val[31:0];
      end
    end
    return v;
  endfunction

  task automatic ref_commit(input vec_t v);
    if (v.we && v.lat == 2)
      for (int i = 0; i < access_size(v.f3); i++) ref_mem[v.addr + 32'(i)] = v.wdata[8*i +: 8];
  endtask

  task automatic apply(input vec_t v, input string nm, input int hold);
    int          lat, wecyc;
    logic [3:0]  be;
    logic [31:0] maddr, mwd, rd;
    logic        mis, flt;
    lat = 0; wecyc = 0; be = 4'h0; maddr = 32'h0; mwd = 32'h0; rd = 32'h0; mis = 1'b0; flt = 1'b0;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    // Keep presenting junk while busy; it must be ignored.
    req_we = ~v.we; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin wecyc++; mwd = mem_wdata; end
      if (mem_be != 4'h0) begin be = be | mem_be; maddr = mem_addr; end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; mis = resp_misaligned; flt = resp_fault;
        break;
      end
    end
    req_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " stall valid"}, 32'(resp_valid), 32'd1);
      chk({nm, " stall rdata"}, resp_rdata, rd);
      chk({nm, " stall flags"}, {30'd0, resp_misaligned, resp_fault}, {30'd0, mis, flt});
      chk({nm, " stall req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, " valid drop"}, 32'(resp_valid), 32'd0);
    chk({nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({nm, " rdata"}, rd, v.rdata);
    chk({nm, " misaligned"}, 32'(mis), 32'(v.mis));
    chk({nm, " fault"}, 32'(flt), 32'(v.fault));
    chk({nm, " we cycles"}, 32'(wecyc), 32'(v.wecyc));
    chk({nm, " be"}, 32'(be), 32'(v.be));
    if (v.lat == 2) chk({nm, " mem_addr"}, maddr, v.addr & 32'hFFFF_FFFC);
    if (v.wecyc == 1) chk({nm, " mem_wdata"}, mwd, v.mwd);
    ref_commit(v);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, " resp_rdata"}, resp_rdata, 32'd0);
    chk({nm, " flags"}, {30'd0, resp_misaligned, resp_fault}, 32'd0);
    chk({nm, " mem_addr"}, mem_addr, 32'd0);
    chk({nm, " mem_wdata"}, mem_wdata, 32'd0);
    chk({nm, " mem_we/be"}, {27'd0, mem_we, mem_be}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b1;
    for (int w = 0; w < MS; w++) begin
      logic [31:0] r;
      r = $urandom;
      dmem[w] = r;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = r[8*b +: 8];
    end

    //        we  f3    addr           wdata          rdata          mis   flt  lat be    wec mwd
    dir.push_back(mk(1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 2, 4'hF, 1, 32'hDEADBEEF));
    dir.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 2, 4'hF, 0, 32'h0));
    dir.push_back(mk(0, 3'd0, 32'h103, 32'h0,        32'hFFFFFFDE, 0, 0, 2, 4'h8, 0, 32'h0));
    dir.push_back(mk(0, 3'd4, 32'h103, 32'h0,        32'h000000DE, 0, 0, 2, 4'h8, 0, 32'h0));
    dir.push_back(mk(0, 3'd1, 32'h102, 32'h0,        32'hFFFFDEAD, 0, 0, 2, 4'hC, 0, 32'h0));
    dir.push_back(mk(0, 3'd5, 32'h100, 32'h0,        32'h0000BEEF, 0, 0, 2, 4'h3, 0, 32'h0));
    dir.push_back(mk(1, 3'd0, 32'h101, 32'hFFFFFF12, 32'h0,        0, 0, 2, 4'h2, 1, 32'h12121212));
    dir.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hDEAD12EF, 0, 0, 2, 4'hF, 0, 32'h0));
    dir.push_back(mk(0, 3'd2, 32'h102, 32'h0,        32'h0,        1, 0, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(0, 3'd2, 32'h1000, 32'h0,       32'h0,        0, 1, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(0, 3'd3, 32'h100, 32'h0,        32'h0,        0, 1, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(1, 3'd1, 32'h102, 32'h1234CAFE, 32'h0,        0, 0, 2, 4'hC, 1, 32'hCAFECAFE));
    dir.push_back(mk(0, 3'd2, 32'h100, 32'h0,        32'hCAFE12EF, 0, 0, 2, 4'hF, 0, 32'h0));
    dir.push_back(mk(1, 3'd4, 32'h100, 32'h55,       32'h0,        0, 1, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(0, 3'd1, 32'h101, 32'h0,        32'h0,        1, 0, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(1, 3'd2, 32'h1002, 32'h1,       32'h0,        1, 0, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(0, 3'd7, 32'h1003, 32'h0,       32'h0,        0, 1, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(1, 3'd0, 32'hFFF, 32'h5A,       32'h0,        0, 0, 2, 4'h8, 1, 32'h5A5A5A5A));
    dir.push_back(mk(0, 3'd0, 32'hFFF, 32'h0,        32'h0000005A, 0, 0, 2, 4'h8, 0, 32'h0));
    dir.push_back(mk(1, 3'd0, 32'hFFE, 32'h80,       32'h0,        0, 0, 2, 4'h4, 1, 32'h80808080));
    dir.push_back(mk(0, 3'd0, 32'hFFE, 32'h0,        32'hFFFFFF80, 0, 0, 2, 4'h4, 0, 32'h0));
    dir.push_back(mk(0, 3'd5, 32'hFFE, 32'h0,        32'h00005A80, 0, 0, 2, 4'hC, 0, 32'h0));
    dir.push_back(mk(0, 3'd5, 32'hFFF, 32'h0,        32'h0,        1, 0, 1, 4'h0, 0, 32'h0));
    dir.push_back(mk(0, 3'd0, 32'h1000, 32'h0,       32'h0,        0, 1, 1, 4'h0, 0, 32'h0));

    #12;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < dir.size(); i++) apply(dir[i], $sformatf("dir%0d", i), 0);

    apply(mk(0, 3'd2, 32'h100, 32'h0, 32'hCAFE12EF, 0, 0, 2, 4'hF, 0, 32'h0), "stall", 3);

    // Reset lands in the ACCESS cycle of a store: the store must not happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h200; req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst access we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("rst mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst no resp", 32'(resp_valid), 32'd0);
    apply(model(1'b0, 3'd2, 32'h200, 32'h0), "rst word", 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 32'h10FF))
                                      : 32'h200 + 32'($urandom_range(0, 63));
      apply(model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom),
            $sformatf("rnd%0d", i), ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
